// File: rtl/mmu_banker_pkg.sv
// mmu_pkg: register-map offsets, mirror address, ROM field codes and
// the common-area size lookup shared by the MMU banker blocks.
package mmu_pkg;

    localparam logic [15:0] MIRROR_BASE = 16'hFF00;
    localparam int          CR_OFS      = 0;
    localparam int          PCR_OFS     = 1;

    typedef enum logic [1:0] {
        ROM_SYS = 2'd0,
        ROM_INT = 2'd1,
        ROM_EXT = 2'd2,
        ROM_RAM = 2'd3
    } rom_fld_e;

    function automatic int mcr_ofs(input int npcr);
        return npcr + 1;
    endfunction

    function automatic int rcr_ofs(input int npcr);
        return npcr + 2;
    endfunction

    function automatic int pl_ofs(input int npcr, input int n);
        return npcr + 3 + 2 * n;
    endfunction

    function automatic int ph_ofs(input int npcr, input int n);
        return npcr + 4 + 2 * n;
    endfunction

    function automatic int xbr_ofs(input int npcr, input int nptr);
        return npcr + 3 + 2 * nptr;
    endfunction

    function automatic int vr_ofs(input int npcr, input int nptr);
        return npcr + 4 + 2 * nptr;
    endfunction

    // Common area size in 256-byte pages
    function automatic logic [7:0] common_pages(input logic [1:0] sz);
        logic [7:0] pages;
        case (sz)
            2'd0:    pages = 8'd4;
            2'd1:    pages = 8'd16;
            2'd2:    pages = 8'd32;
            default: pages = 8'd64;
        endcase
        return pages;
    endfunction

endpackage

// File: rtl/mmu_banker_if.sv
// mmu_banker_if: CPU-side bus of the MMU banker plus its translated
// outputs towards DRAM/ROM decode.
interface mmu_banker_if #(
    parameter int BANK_BITS = 2
);
    logic                 rw;
    logic [15:0]          addr;
    logic [7:0]           d_in;
    logic [7:0]           d_out;
    logic                 d_oe;
    logic [BANK_BITS-1:0] bank;
    logic [7:0]           ta_hi;
    logic                 io_sel;
    logic [2:0]           rom_sel;
    logic                 mmu_hit;
    logic [7:0]           mcr;

    modport master (
        output rw, addr, d_in,
        input  d_out, d_oe, bank, ta_hi,
        input  io_sel, rom_sel, mmu_hit, mcr
    );

    modport slave (
        input  rw, addr, d_in,
        output d_out, d_oe, bank, ta_hi,
        output io_sel, rom_sel, mmu_hit, mcr
    );
endinterface

// File: rtl/mmu_banker_xlat.sv
// mmu_xlat: combinational address translation and I/O / ROM select.
// Define MMU_SWAP_EN to enable the reverse (swap) page mapping.
module mmu_xlat
    import mmu_pkg::*;
#(
    parameter int NUM_PAGEPTR = 2,
    parameter int BANK_BITS   = 2
) (
    input  logic                                  i_rw,
    input  logic [15:0]                           i_addr,
    input  logic [5:0]                            i_cr,
    input  logic [3:0]                            i_rcr,
    input  logic [BANK_BITS-1:0]                  i_ebank,
    input  logic [NUM_PAGEPTR-1:0][7:0]           i_pl,
    input  logic [NUM_PAGEPTR-1:0][BANK_BITS-1:0] i_ph,
    input  logic                                  i_hit,
    output logic [BANK_BITS-1:0]                  o_bank,
    output logic [7:0]                            o_ta_hi,
    output logic                                  o_io_sel,
    output logic [2:0]                            o_rom_sel
);
    logic [7:0] w_hi;
    logic [7:0] w_pages;
    logic       w_com;
    logic       w_io;
    logic       w_ff0;

    assign w_hi    = i_addr[15:8];
    assign w_pages = common_pages(i_rcr[1:0]);
    // ~hi < pages is hi >= 256 - pages without a 9-bit subtract
    assign w_com   = (i_rcr[2] && (w_hi < w_pages))
                   || (i_rcr[3] && (~w_hi < w_pages));

    always_comb begin
        o_bank  = i_ebank;
        o_ta_hi = w_hi;
        if (w_com)
            o_bank = '0;
`ifdef MMU_SWAP_EN
        for (int n = 0; n < NUM_PAGEPTR; n++) begin
            if (w_hi == i_pl[n] && i_ebank == i_ph[n]) begin
                o_bank  = i_ebank;
                o_ta_hi = 8'(n);
            end
        end
`endif
        for (int n = 0; n < NUM_PAGEPTR; n++) begin
            if (w_hi == 8'(n)) begin
                o_bank  = i_ph[n];
                o_ta_hi = i_pl[n];
            end
        end
    end

    assign w_ff0    = (i_addr[15:4] == 12'hFF0);
    assign w_io     = ~i_cr[0] & (w_hi[7:4] == 4'hD) & ~i_hit;
    assign o_io_sel = w_io;

    assign o_rom_sel[0] = i_rw & ~i_hit & (w_hi[7:6] == 2'b01)
                        & ~i_cr[1];
    assign o_rom_sel[1] = i_rw & ~i_hit & (w_hi[7:6] == 2'b10)
                        & (rom_fld_e'(i_cr[3:2]) == ROM_SYS);
    assign o_rom_sel[2] = i_rw & ~i_hit & (w_hi[7:6] == 2'b11)
                        & (rom_fld_e'(i_cr[5:4]) == ROM_SYS)
                        & ~w_io & ~w_ff0;

endmodule

// File: rtl/mmu_banker.sv
// mmu_banker: MMU register file plus registered address translation.
// Optional macro MMU_SWAP_EN enables reverse page mapping (swap).
module mmu_banker
    import mmu_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD500,
    parameter int          NUM_PCR     = 4,
    parameter int          NUM_PAGEPTR = 2,
    parameter int          BANK_BITS   = 2,
    parameter logic [7:0]  VERSION     = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    mmu_banker_if.slave bus
);
    localparam int MCR_O = mcr_ofs(NUM_PCR);
    localparam int RCR_O = rcr_ofs(NUM_PCR);
    localparam int XBR_O = xbr_ofs(NUM_PCR, NUM_PAGEPTR);
    localparam int VR_O  = vr_ofs(NUM_PCR, NUM_PAGEPTR);

    logic [7:0]                            r_cr;
    logic [NUM_PCR:1][7:0]                 r_pcr;
    logic [7:0]                            r_mcr;
    logic [7:0]                            r_rcr;
    logic [7:0]                            r_xbr;
    logic [NUM_PAGEPTR-1:0][7:0]           r_pl;
    logic [NUM_PAGEPTR-1:0][7:0]           r_ph;
    logic [NUM_PAGEPTR-1:0][7:0]           r_lat;

    logic [BANK_BITS-1:0]                  r_bank;
    logic [7:0]                            r_ta_hi;
    logic                                  r_io_sel;
    logic [2:0]                            r_rom_sel;
    logic                                  r_mmu_hit;

    logic [15:0]                           w_wofs;
    logic [15:0]                           w_mofs;
    logic [7:0]                            w_ofs;
    logic                                  w_in_win;
    logic                                  w_in_mir;
    logic                                  w_hit;
    logic [7:0]                            w_rd;
    logic [BANK_BITS-1:0]                  w_ebank;
    logic [NUM_PAGEPTR-1:0][BANK_BITS-1:0] w_ph_b;
    logic [BANK_BITS-1:0]                  w_bank;
    logic [7:0]                            w_ta_hi;
    logic                                  w_io_sel;
    logic [2:0]                            w_rom_sel;

    // Main map lives in I/O space, so it disappears with CR[0]
    assign w_wofs   = bus.addr - BASE_ADDR;
    assign w_ofs    = w_wofs[7:0];
    assign w_in_win = (w_wofs[15:8] == 8'h00) && !r_cr[0];
    assign w_mofs   = bus.addr - MIRROR_BASE;
    assign w_in_mir = (w_mofs <= 16'(NUM_PCR));
    assign w_hit    = w_in_win | w_in_mir;

    generate
        if (BANK_BITS <= 2) begin : g_bank_lo
            assign w_ebank = r_cr[6 +: BANK_BITS];
        end else begin : g_bank_hi
            assign w_ebank = {r_xbr[BANK_BITS-3:0], r_cr[7:6]};
        end
    endgenerate

    always_comb begin
        for (int n = 0; n < NUM_PAGEPTR; n++)
            w_ph_b[n] = r_ph[n][BANK_BITS-1:0];
    end

    always_comb begin
        w_rd = 8'hFF;
        if (w_in_mir) begin
            w_rd = r_cr;
            for (int k = 1; k <= NUM_PCR; k++)
                if (w_mofs == 16'(k)) w_rd = r_pcr[k];
        end else if (w_in_win) begin
            if (w_ofs == 8'(CR_OFS)) w_rd = r_cr;
            for (int k = 1; k <= NUM_PCR; k++)
                if (w_ofs == 8'(PCR_OFS + k - 1)) w_rd = r_pcr[k];
            if (w_ofs == 8'(MCR_O)) w_rd = r_mcr;
            if (w_ofs == 8'(RCR_O)) w_rd = r_rcr;
            for (int n = 0; n < NUM_PAGEPTR; n++) begin
                if (w_ofs == 8'(pl_ofs(NUM_PCR, n))) w_rd = r_pl[n];
                if (w_ofs == 8'(ph_ofs(NUM_PCR, n))) w_rd = r_ph[n];
            end
            if (w_ofs == 8'(XBR_O)) w_rd = r_xbr;
            if (w_ofs == 8'(VR_O))  w_rd = VERSION;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cr  <= '0;
            r_pcr <= '0;
            r_mcr <= '0;
            r_rcr <= '0;
            r_xbr <= '0;
            r_ph  <= '0;
            r_lat <= '0;
            for (int n = 0; n < NUM_PAGEPTR; n++)
                r_pl[n] <= 8'(n);
        end else if (!bus.rw) begin
            if (w_in_mir) begin
                if (w_mofs == 16'd0) r_cr <= bus.d_in;
                for (int k = 1; k <= NUM_PCR; k++)
                    if (w_mofs == 16'(k)) r_cr <= r_pcr[k];
            end else if (w_in_win) begin
                if (w_ofs == 8'(CR_OFS)) r_cr <= bus.d_in;
                for (int k = 1; k <= NUM_PCR; k++)
                    if (w_ofs == 8'(PCR_OFS + k - 1)) r_pcr[k] <= bus.d_in;
                if (w_ofs == 8'(MCR_O)) r_mcr <= bus.d_in;
                if (w_ofs == 8'(RCR_O)) r_rcr <= bus.d_in;
                // PnH stages in a latch and commits with PnL
                for (int n = 0; n < NUM_PAGEPTR; n++) begin
                    if (w_ofs == 8'(pl_ofs(NUM_PCR, n))) begin
                        r_pl[n] <= bus.d_in;
                        r_ph[n] <= r_lat[n];
                    end
                    if (w_ofs == 8'(ph_ofs(NUM_PCR, n)))
                        r_lat[n] <= bus.d_in;
                end
                if (w_ofs == 8'(XBR_O)) r_xbr <= bus.d_in;
            end
        end
    end

    mmu_xlat #(
        .NUM_PAGEPTR (NUM_PAGEPTR),
        .BANK_BITS   (BANK_BITS)
    ) u_xlat (
        .i_rw      (bus.rw),
        .i_addr    (bus.addr),
        .i_cr      (r_cr[5:0]),
        .i_rcr     (r_rcr[3:0]),
        .i_ebank   (w_ebank),
        .i_pl      (r_pl),
        .i_ph      (w_ph_b),
        .i_hit     (w_hit),
        .o_bank    (w_bank),
        .o_ta_hi   (w_ta_hi),
        .o_io_sel  (w_io_sel),
        .o_rom_sel (w_rom_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank    <= '0;
            r_ta_hi   <= '0;
            r_io_sel  <= 1'b0;
            r_rom_sel <= '0;
            r_mmu_hit <= 1'b0;
        end else begin
            r_bank    <= w_bank;
            r_ta_hi   <= w_ta_hi;
            r_io_sel  <= w_io_sel;
            r_rom_sel <= w_rom_sel;
            r_mmu_hit <= w_hit;
        end
    end

    assign bus.d_out   = w_rd;
    assign bus.d_oe    = bus.rw & w_hit;
    assign bus.bank    = r_bank;
    assign bus.ta_hi   = r_ta_hi;
    assign bus.io_sel  = r_io_sel;
    assign bus.rom_sel = r_rom_sel;
    assign bus.mmu_hit = r_mmu_hit;
    assign bus.mcr     = r_mcr;

endmodule

// File: tb/tb_mmu_banker.sv
// tb_mmu_banker: directed vectors for the MMU banker register file
// and translation pipeline.
module tb_mmu_banker;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    mmu_banker_if #(.BANK_BITS(2)) bus ();

    mmu_banker #(
        .BASE_ADDR   (16'hD500),
        .NUM_PCR     (4),
        .NUM_PAGEPTR (2),
        .BANK_BITS   (2),
        .VERSION     (8'h20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.rw   = 1'b0;
        bus.addr = a;
        bus.d_in = d;
        @(posedge clk);
        #1;
        bus.rw = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [15:0] a,
                      input logic [7:0] exp);
        bus.rw   = 1'b1;
        bus.addr = a;
        #1;
        chk(tag, 16'({bus.d_oe, bus.d_out}), 16'({1'b1, exp}));
    endtask

    task automatic xl(input logic rw, input logic [15:0] a);
        bus.rw   = rw;
        bus.addr = a;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_rst [13];
    logic [7:0] swap_ta;

    initial begin
        n_chk    = 0;
        n_err    = 0;
        reset    = 1'b1;
        bus.rw   = 1'b1;
        bus.addr = 16'h0000;
        bus.d_in = 8'h00;
        exp_rst  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h20};
`ifdef MMU_SWAP_EN
        swap_ta = 8'h00;
`else
        swap_ta = 8'h20;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bank", 16'(bus.bank), 16'h0);
        chk("rst_ta_hi", 16'(bus.ta_hi), 16'h0);
        chk("rst_io", 16'(bus.io_sel), 16'h0);
        chk("rst_rom", 16'(bus.rom_sel), 16'h0);
        chk("rst_hit", 16'(bus.mmu_hit), 16'h0);
        chk("rst_mcr", 16'(bus.mcr), 16'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            rd($sformatf("rst_reg%0d", i), 16'hD500 + 16'(i), exp_rst[i]);
        rd("rst_ff00", 16'hFF00, 8'h00);
        rd("unused_d540", 16'hD540, 8'hFF);

        wr(16'hD500, 8'h55);
        rd("cr_mirror", 16'hFF00, 8'h55);
        xl(1'b0, 16'h4000);
        chk("wr4000_bank", 16'(bus.bank), 16'h1);
        chk("wr4000_rom", 16'(bus.rom_sel), 16'h0);
        xl(1'b1, 16'h4000);
        chk("rd4000_rom", 16'(bus.rom_sel), 16'h1);

        wr(16'hFF00, 8'h00);
        wr(16'hD503, 8'hC0);
        rd("pcr3", 16'hD503, 8'hC0);
        wr(16'hFF03, 8'h5A);
        rd("lcr3_cr", 16'hFF00, 8'hC0);
        rd("lcr3_rd", 16'hFF03, 8'hC0);
        xl(1'b1, 16'h1234);
        chk("b3_bank", 16'(bus.bank), 16'h3);
        chk("b3_ta", 16'(bus.ta_hi), 16'h12);
        xl(1'b1, 16'hD000);
        chk("io_sel", 16'(bus.io_sel), 16'h1);
        chk("io_rom", 16'(bus.rom_sel), 16'h0);
        xl(1'b1, 16'hE000);
        chk("rom_hi", 16'(bus.rom_sel), 16'h4);
        xl(1'b1, 16'h8000);
        chk("rom_mid", 16'(bus.rom_sel), 16'h2);
        xl(1'b1, 16'hFF05);
        chk("ff05_rom", 16'(bus.rom_sel), 16'h0);
        chk("ff05_hit", 16'(bus.mmu_hit), 16'h0);
        xl(1'b1, 16'hFF04);
        chk("ff04_hit", 16'(bus.mmu_hit), 16'h1);
        chk("ff04_rom", 16'(bus.rom_sel), 16'h0);
        xl(1'b1, 16'hD505);
        chk("d505_hit", 16'(bus.mmu_hit), 16'h1);
        chk("d505_io", 16'(bus.io_sel), 16'h0);

        wr(16'hD508, 8'h01);
        rd("p0h_latch", 16'hD508, 8'h00);
        wr(16'hD507, 8'h20);
        rd("p0h_commit", 16'hD508, 8'h01);
        rd("p0l", 16'hD507, 8'h20);
        xl(1'b1, 16'h0010);
        chk("p0_bank", 16'(bus.bank), 16'h1);
        chk("p0_ta", 16'(bus.ta_hi), 16'h20);
        wr(16'hFF00, 8'h40);
        xl(1'b1, 16'h2000);
        chk("swap_bank", 16'(bus.bank), 16'h1);
        chk("swap_ta", 16'(bus.ta_hi), 16'(swap_ta));
        xl(1'b1, 16'h0100);
        chk("p1_id_bank", 16'(bus.bank), 16'h0);
        chk("p1_id_ta", 16'(bus.ta_hi), 16'h01);
        xl(1'b1, 16'h5000);
        chk("plain_ta", 16'(bus.ta_hi), 16'h50);

        wr(16'hD50B, 8'h03);
        rd("xbr", 16'hD50B, 8'h03);
        wr(16'hD50C, 8'h00);
        rd("vr_ro", 16'hD50C, 8'h20);
        wr(16'hD505, 8'hA5);
        chk("mcr_out", 16'(bus.mcr), 16'hA5);
        wr(16'hD506, 8'h0F);
        xl(1'b1, 16'hF000);
        chk("com_f000", 16'(bus.bank), 16'h0);
        xl(1'b1, 16'h1000);
        chk("com_1000", 16'(bus.bank), 16'h0);
        xl(1'b1, 16'h3F00);
        chk("com_3f00", 16'(bus.bank), 16'h0);
        xl(1'b1, 16'h4000);
        chk("com_4000", 16'(bus.bank), 16'h1);
        xl(1'b1, 16'hBF00);
        chk("com_bf00", 16'(bus.bank), 16'h1);
        xl(1'b1, 16'hC000);
        chk("com_c000", 16'(bus.bank), 16'h0);
        xl(1'b1, 16'h0010);
        chk("com_ptr", 16'(bus.bank), 16'h1);
        xl(1'b1, 16'h8000);
        chk("com_8000", 16'(bus.bank), 16'h1);

        bus.rw   = 1'b0;
        bus.addr = 16'hD500;
        bus.d_in = 8'h77;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cr", 16'(bus.d_out), 16'h00);
        chk("arst_bank", 16'(bus.bank), 16'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.rw = 1'b1;
        rd("arst_cr_rd", 16'hFF00, 8'h00);
        rd("arst_p0l", 16'hD507, 8'h00);
        rd("arst_p0h", 16'hD508, 8'h00);
        chk("arst_mcr", 16'(bus.mcr), 16'h00);
        wr(16'hD507, 8'h33);
        rd("arst_latch", 16'hD508, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
